// File: rtl/block_pkg.sv
// Shared types and helpers for the block packer datapath.
package block_pkg;

    localparam int NUM_W = 32;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Clamp a block count to the number of block slots actually present.
    function automatic logic [NUM_W-1:0] min_clamp(
        input logic [NUM_W-1:0] num,
        input logic [NUM_W-1:0] max
    );
        return (num < max) ? num : max;
    endfunction

endpackage

// File: rtl/block_insert.sv
// Combinational placement of up to IN_BLOCKS input blocks into the packing
// buffer, starting at block offset `off`. Positions outside off..off+n-1
// pass through unchanged.
module block_insert #(
    parameter  int BLOCK_SIZE = 64,
    parameter  int IN_BLOCKS  = 2,
    parameter  int CAP        = 5,
    localparam int CNT_W      = $clog2(CAP + 1)
) (
    input  logic [CAP*BLOCK_SIZE-1:0]       buf_in,
    input  logic [IN_BLOCKS*BLOCK_SIZE-1:0] in_data,
    input  logic [CNT_W-1:0]                n,
    input  logic [CNT_W-1:0]                off,
    output logic [CAP*BLOCK_SIZE-1:0]       buf_out
);

    genvar gi;
    generate
        for (gi = 0; gi < CAP; gi++) begin : g_pos
            logic [BLOCK_SIZE-1:0] blk;

            // Each buffer slot selects the input block that lands on it, if any.
            always_comb begin
                blk = buf_in[gi*BLOCK_SIZE +: BLOCK_SIZE];
                for (int j = 0; j < IN_BLOCKS; j++) begin
                    if ((j < int'(n)) && ((int'(off) + j) == gi)) begin
                        blk = in_data[j*BLOCK_SIZE +: BLOCK_SIZE];
                    end
                end
            end

            assign buf_out[gi*BLOCK_SIZE +: BLOCK_SIZE] = blk;
        end
    endgenerate

endmodule

// File: rtl/block_packer.sv
// Packs variable-count block bundles into dense OUT_BLOCKS-wide words.
// A `last` bundle forces the remaining partial (or empty) word out, tagged
// final. Accepting and emitting are mutually exclusive, so in_ready depends
// only on registered state.
module block_packer
    import block_pkg::*;
#(
    parameter int BLOCK_SIZE = 64,
    parameter int IN_BLOCKS  = 2,
    parameter int OUT_BLOCKS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [IN_BLOCKS*BLOCK_SIZE-1:0]  in_data,
    input  logic                             in_valid,
    input  logic [NUM_W-1:0]                 in_num,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [OUT_BLOCKS*BLOCK_SIZE-1:0] out_data,
    output logic                             out_valid,
    output logic [NUM_W-1:0]                 out_num,
    output logic                             out_last,
    input  logic                             out_ready
);

    localparam int CAP   = OUT_BLOCKS + IN_BLOCKS - 1;
    localparam int CNT_W = $clog2(CAP + 1);
    localparam int BUF_W = CAP * BLOCK_SIZE;
    localparam int OUT_W = OUT_BLOCKS * BLOCK_SIZE;
    localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_BLOCKS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [NUM_W-1:0]  out_num_q, out_num_d;
    logic              out_last_q, out_last_d;

    logic [CNT_W-1:0]  n_eff;
    logic [BUF_W-1:0]  buf_ins;
    logic [OUT_W-1:0]  part_data;
    logic              accept;
    logic              can_load;
    logic              emit_full;
    logic              emit_flush;

    assign n_eff = CNT_W'(min_clamp(in_num, NUM_W'(IN_BLOCKS)));

    block_insert #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .IN_BLOCKS  (IN_BLOCKS),
        .CAP        (CAP)
    ) u_insert (
        .buf_in  (buf_q),
        .in_data (in_data),
        .n       (n_eff),
        .off     (cnt_q),
        .buf_out (buf_ins)
    );

    // Output comb: ready only while filling with room for a whole bundle.
    always_comb begin
        in_ready = rst_n && (state_q == FILL) && (cnt_q < OUT_CNT);
    end

    // Partial word: keep the first cnt blocks, zero the rest.
    always_comb begin
        part_data = buf_q[OUT_W-1:0];
        for (int b = 0; b < OUT_BLOCKS; b++) begin
            if (b >= int'(cnt_q)) begin
                part_data[b*BLOCK_SIZE +: BLOCK_SIZE] = '0;
            end
        end
    end

    // Next-state comb: either take a bundle into the buffer or move a word out.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_num_d   = out_num_q;
        out_last_d  = out_last_q;

        accept     = in_valid && in_ready;
        can_load   = !out_valid_q || out_ready;
        emit_full  = (cnt_q >= OUT_CNT);
        emit_flush = (state_q == FLUSH) && !emit_full;

        if (accept) begin
            buf_d = buf_ins;
            cnt_d = cnt_q + n_eff;
            if (in_last) begin
                state_d = FLUSH;
            end
        end

        if (can_load && emit_full) begin
            out_data_d  = buf_q[OUT_W-1:0];
            out_num_d   = NUM_W'(OUT_BLOCKS);
            out_last_d  = (state_q == FLUSH) && (cnt_q == OUT_CNT);
            out_valid_d = 1'b1;
            buf_d       = buf_q >> OUT_W;
            cnt_d       = cnt_q - OUT_CNT;
            // An exact final word already carries last; no trailing empty word.
            if ((state_q == FLUSH) && (cnt_q == OUT_CNT)) begin
                state_d = FILL;
            end
        end else if (can_load && emit_flush) begin
            // Covers both partial (cnt>0) and empty (cnt==0) final words.
            out_data_d  = part_data;
            out_num_d   = NUM_W'(cnt_q);
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            buf_d       = '0;
            cnt_d       = '0;
            state_d     = FILL;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            buf_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_num_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_num_q   <= out_num_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_num   = out_num_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_block_packer.sv
// Self-checking bench for block_packer: a table of single-bundle vectors with
// cycle-level expectations, hand-written backpressure and reset sequences,
// and a randomized stream checked against a block-queue reference model.
module tb_block_packer;

    localparam int BS   = 64;
    localparam int INB  = 2;
    localparam int OUTB = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [INB*BS-1:0]   in_data;
    logic                in_valid;
    logic [31:0]         in_num;
    logic                in_last;
    logic                in_ready;
    logic [OUTB*BS-1:0]  out_data;
    logic                out_valid;
    logic [31:0]         out_num;
    logic                out_last;
    logic                out_ready;

    int checks   = 0;
    int failures = 0;
    int words    = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [OUTB*BS-1:0] data;
        int                 num;
        bit                 last;
    } word_t;

    word_t       exp_q[$];
    logic [BS-1:0] blk_q[$];

    typedef struct {
        int num;
        bit last;
        bit rdy_acc;   // in_ready just after the accept edge
        bit v;         // out_valid one edge later
        int onum;
        bit olast;
        bit rdy;       // in_ready one edge later
    } vec_t;

    vec_t tbl[14];

    block_packer #(
        .BLOCK_SIZE (BS),
        .IN_BLOCKS  (INB),
        .OUT_BLOCKS (OUTB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_num    (in_num),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_num   (out_num),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference model: a flat FIFO of blocks, cut into words of OUTB.
    task automatic model_accept(input logic [INB*BS-1:0] d, input int num, input bit last);
        int n;
        word_t w;
        n = (num > INB) ? INB : num;
        for (int j = 0; j < n; j++) blk_q.push_back(d[j*BS +: BS]);
        while (blk_q.size() >= OUTB) begin
            w.data = '0;
            for (int k = 0; k < OUTB; k++) w.data[k*BS +: BS] = blk_q.pop_front();
            w.num  = OUTB;
            w.last = last && (blk_q.size() == 0);
            exp_q.push_back(w);
            if (w.last) return;
        end
        if (last) begin
            w.data = '0;
            w.num  = blk_q.size();
            w.last = 1'b1;
            for (int k = 0; k < w.num; k++) w.data[k*BS +: BS] = blk_q.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic send(input logic [INB*BS-1:0] d, input int num, input bit last);
        int waited;
        waited   = 0;
        in_data  = d;
        in_num   = num;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        model_accept(d, num, last);
    endtask

    function automatic logic [INB*BS-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output monitor: one line per completed output handshake.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                words++;
                $display("word %0d: num=%0d last=%0d data=%h", words, out_num, out_last, out_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got num=%0d, required no word", out_num);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_num", out_num, e.num);
                    check("word_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{2, 0, 1, 0, 0, 0, 1};
        tbl[1]  = '{2, 0, 0, 1, 4, 0, 1};
        tbl[2]  = '{1, 0, 1, 0, 0, 0, 1};
        tbl[3]  = '{2, 0, 1, 0, 0, 0, 1};
        tbl[4]  = '{2, 0, 0, 1, 4, 0, 1};
        tbl[5]  = '{2, 1, 0, 1, 3, 1, 1};
        tbl[6]  = '{0, 1, 0, 1, 0, 1, 1};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 1};
        tbl[8]  = '{7, 0, 1, 0, 0, 0, 1};
        tbl[9]  = '{2, 1, 0, 1, 4, 1, 1};
        tbl[10] = '{1, 0, 1, 0, 0, 0, 1};
        tbl[11] = '{2, 0, 1, 0, 0, 0, 1};
        tbl[12] = '{2, 1, 0, 1, 4, 0, 0};
        tbl[13] = '{3, 1, 0, 1, 2, 1, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_num    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_num", out_num, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1);

        // Table-driven single bundles with out_ready held high
        for (int i = 0; i < 14; i++) begin
            send(rand_data(), tbl[i].num, tbl[i].last);
            check($sformatf("tbl%0d_rdy_acc", i), in_ready, tbl[i].rdy_acc);
            step();
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
            if (tbl[i].v) begin
                check($sformatf("tbl%0d_num", i), out_num, tbl[i].onum);
                check($sformatf("tbl%0d_last", i), out_last, tbl[i].olast);
            end
            check($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].rdy);
        end
        step();
        step();

        // Backpressure: a held word, then a full buffer stuck behind it
        out_ready = 1'b0;
        send(rand_data(), 2, 0);
        send(rand_data(), 2, 0);
        step();
        check("bp_latency_valid", out_valid, 1);
        send(rand_data(), 7, 0);
        send(rand_data(), 2, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, exp_q[0].data);
            check("bp_hold_num", out_num, 4);
            check("bp_hold_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", out_valid, 1);
        check("bp_release_next_data", out_data, exp_q[0].data);
        step();
        step();

        // Reset while a flush is pending behind a held word
        out_ready = 1'b0;
        send(rand_data(), 2, 0);
        send(rand_data(), 2, 0);
        step();
        send(rand_data(), 1, 1);
        step();
        check("rstmid_pre_valid", out_valid, 1);
        check("rstmid_pre_in_ready", in_ready, 0);
        rst_n = 1'b0;
        step();
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_num", out_num, 0);
        check("rstmid_out_last", out_last, 0);
        check("rstmid_in_ready_low", in_ready, 0);
        exp_q.delete();
        blk_q.delete();
        rst_n = 1'b1;
        #1;
        check("rstmid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        send(rand_data(), 2, 0);
        send(rand_data(), 2, 0);
        step();
        check("rstmid_cnt0_valid", out_valid, 1);
        check("rstmid_cnt0_num", out_num, 4);
        step();

        // Randomized stream with random backpressure and gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int num;
            if ($urandom_range(0, 3) == 0) step();
            num = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) num = 7;
            send(rand_data(), num, ($urandom_range(0, 5) == 0));
        end
        send(rand_data(), 1, 1);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        check("drain_empty", exp_q.size(), 0);
        step();
        step();
        check("drain_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
